adc_frame_uart: RTL and testbench



---
 rtl/adc_frame_uart.sv | 200 ++++++++++++++++++++
 tb/tb_adc_frame_uart.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_uart.sv
// adc_frame_uart: captures DEPTH decimated 12-bit ADC samples into a local RAM,
// then streams them out as 8N1 UART bytes:
//   A5, 5A, then {4'h0, s[11:8]}, s[7:0] for each sample.
// Optional build macro ADC_FRAME_CHECKSUM_EN appends one XOR byte
// computed over all payload bytes.
// txd/busy/done are registered from the current state, so they lag the
// internal state by one clock.
module adc_frame_uart #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 256,
    parameter int DECIM  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] date_in,
    input  logic        start,
    output logic        txd,
    output logic        busy,
    output logic        done
);

    localparam int BAUD_DIV = CLK_HZ / BAUD;
    localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef ADC_FRAME_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_CAPTURE, S_HDR0, S_HDR1, S_SHI, S_SLO, S_SUM, S_FIN
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_CAPTURE, S_HDR0, S_HDR1, S_SHI, S_SLO, S_FIN
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [15:0]     dec_q, dec_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [BW-1:0]   baud_cnt_q, baud_cnt_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic            txd_q, txd_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [11:0]     ram [DEPTH];
    logic [11:0]     rd_data_q;
    logic [7:0]      cur_byte;
    logic [2:0]      bit_sel;
    logic            tx_active;
    logic            byte_end;
    logic            sample_en;

    assign sample_en = (state_q == S_CAPTURE) && (dec_q == 16'd0);
    assign tx_active = (state_q != S_IDLE) && (state_q != S_CAPTURE) && (state_q != S_FIN);
    assign byte_end  = tx_active && (baud_cnt_q == BW'(BAUD_DIV - 1)) && (bit_cnt_q == 4'd9);
    assign bit_sel   = 3'(bit_cnt_q - 4'd1);

`ifdef ADC_FRAME_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    // Running XOR of payload bytes, accumulated as each sample byte completes.
    always_comb begin
        sum_d = sum_q;
        if (state_q == S_IDLE)
            sum_d = 8'h00;
        else if (byte_end && ((state_q == S_SHI) || (state_q == S_SLO)))
            sum_d = sum_q ^ cur_byte;
    end

    // Checksum register; cleared in IDLE before every frame.
    always_ff @(posedge clk) begin
        sum_q <= sum_d;
    end
`endif

    // Byte currently on the wire, selected by state.
    always_comb begin
        cur_byte = 8'hFF;
        case (state_q)
            S_HDR0: cur_byte = 8'hA5;
            S_HDR1: cur_byte = 8'h5A;
            S_SHI:  cur_byte = {4'h0, rd_data_q[11:8]};
            S_SLO:  cur_byte = rd_data_q[7:0];
`ifdef ADC_FRAME_CHECKSUM_EN
            S_SUM:  cur_byte = sum_q;
`endif
            default: cur_byte = 8'hFF;
        endcase
    end

    // State register and control counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            dec_q      <= 16'd0;
            idx_q      <= '0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            dec_q      <= dec_d;
            idx_q      <= idx_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    // Next-state logic; each transmit state lasts exactly one byte.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_CAPTURE;
            S_CAPTURE: if (sample_en && (idx_q == AW'(DEPTH - 1))) state_d = S_HDR0;
            S_HDR0:    if (byte_end) state_d = S_HDR1;
            S_HDR1:    if (byte_end) state_d = S_SHI;
            S_SHI:     if (byte_end) state_d = S_SLO;
            S_SLO: begin
                if (byte_end) begin
                    if (idx_q != AW'(DEPTH - 1))
                        state_d = S_SHI;
                    else
`ifdef ADC_FRAME_CHECKSUM_EN
                        state_d = S_SUM;
`else
                        state_d = S_FIN;
`endif
                end
            end
`ifdef ADC_FRAME_CHECKSUM_EN
            S_SUM:     if (byte_end) state_d = S_FIN;
`endif
            S_FIN:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Decimation, sample index (shared by capture and transmit) and baud/bit counters.
    always_comb begin
        dec_d      = dec_q;
        idx_d      = idx_q;
        baud_cnt_d = '0;
        bit_cnt_d  = 4'd0;
        if (state_q == S_IDLE) begin
            dec_d = 16'd0;
            idx_d = '0;
        end else if (state_q == S_CAPTURE) begin
            dec_d = (dec_q == 16'(DECIM - 1)) ? 16'd0 : dec_q + 16'd1;
            if (sample_en) idx_d = idx_q + AW'(1);
        end else if ((state_q == S_SLO) && byte_end) begin
            idx_d = idx_q + AW'(1);
        end
        if (tx_active) begin
            if (baud_cnt_q == BW'(BAUD_DIV - 1)) begin
                baud_cnt_d = '0;
                bit_cnt_d  = (bit_cnt_q == 4'd9) ? 4'd0 : bit_cnt_q + 4'd1;
            end else begin
                baud_cnt_d = baud_cnt_q + BW'(1);
                bit_cnt_d  = bit_cnt_q;
            end
        end
    end

    // Output decode: start/data/stop bit framing plus status flags.
    always_comb begin
        busy_d = (state_q != S_IDLE) && (state_q != S_FIN);
        done_d = (state_q == S_FIN);
        txd_d  = 1'b1;
        if (tx_active) begin
            case (bit_cnt_q)
                4'd0:    txd_d = 1'b0;
                4'd9:    txd_d = 1'b1;
                default: txd_d = cur_byte[bit_sel];
            endcase
        end
    end

    // Registered outputs; reset forces the line idle immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txd_q  <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            txd_q  <= txd_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Sample RAM; read address is the next index so data is ready when a sample's bytes start.
    always_ff @(posedge clk) begin
        if (sample_en) ram[idx_q] <= date_in;
        rd_data_q <= ram[idx_d];
    end

    assign txd  = txd_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_adc_frame_uart.sv
// Directed bench for adc_frame_uart: two instances (DECIM=1 and DECIM=3),
// each with a UART receiver that records the bytes it decodes.
module tb_adc_frame_uart;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int DEPTH  = 4;
`ifdef ADC_FRAME_CHECKSUM_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk;
    logic        rst;
    logic        start_a, start_b;
    logic [11:0] date_a, date_b;
    logic        txd_a, busy_a, done_a;
    logic        txd_b, busy_b, done_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt_a = 0;
    int bfall_a    = 0;
    logic busy_prev_a = 1'b0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic [7:0] exp_bytes [11];

    adc_frame_uart #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH), .DECIM(1)) dut_a (
        .clk(clk), .rst(rst), .date_in(date_a), .start(start_a),
        .txd(txd_a), .busy(busy_a), .done(done_a)
    );

    adc_frame_uart #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH), .DECIM(3)) dut_b (
        .clk(clk), .rst(rst), .date_in(date_b), .start(start_b),
        .txd(txd_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
        busy_prev_a <= busy_a;
        if (busy_prev_a === 1'b1 && busy_a === 1'b0) bfall_a <= bfall_a + 1;
    end

    // 8N1 receiver: detect the start bit on a falling clock, sample each bit at its centre.
    task automatic rx_loop(input int which);
        logic       b;
        logic [7:0] byt;
        forever begin
            @(negedge clk);
            b = (which == 0) ? txd_a : txd_b;
            if (b === 1'b0) begin
                repeat (4) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (10) @(negedge clk);
                    byt[k] = (which == 0) ? txd_a : txd_b;
                end
                repeat (10) @(negedge clk);
                if (which == 0) q_a.push_back(byt);
                else            q_b.push_back(byt);
            end
        end
    endtask

    initial rx_loop(0);
    initial rx_loop(1);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int which, input int budget, output int at);
        logic d;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            d = (which == 0) ? done_a : done_b;
            if (d === 1'b1) begin
                at = cyc;
                break;
            end
        end
        check("done_within_budget", 32'(at >= 0), 32'd1);
    endtask

    task automatic check_frame(input int which, input string tag, input int n);
        int          sz;
        logic [31:0] got;
        sz = (which == 0) ? q_a.size() : q_b.size();
        check($sformatf("%s_len", tag), 32'(sz), 32'(n));
        for (int k = 0; k < n; k++) begin
            if (k < sz) got = (which == 0) ? {24'h0, q_a[k]} : {24'h0, q_b[k]};
            else        got = 32'hFFFF_FFFF;
            check($sformatf("%s_byte%0d", tag, k), got, {24'h0, exp_bytes[k]});
        end
    endtask

    // Launches a DUT-A frame with samples 123, ABC, 000, FFF; optional start pulse during CAPTURE.
    // Returns n_edge = index of the clock edge that accepts start; exits at cyc = n_edge+4.
    task automatic send_a(input logic pulse_cap, output int n_edge);
        start_a = 1'b1;
        date_a  = 12'h000;
        n_edge  = cyc + 1;
        @(negedge clk); start_a = 1'b0;      date_a = 12'h123;
        @(negedge clk); start_a = pulse_cap; date_a = 12'hABC;
        @(negedge clk); start_a = 1'b0;      date_a = 12'h000;
        @(negedge clk);                      date_a = 12'hFFF;
        @(negedge clk);                      date_a = 12'h000;
    endtask

    task automatic set_exp_a();
        exp_bytes[0] = 8'hA5; exp_bytes[1] = 8'h5A;
        exp_bytes[2] = 8'h01; exp_bytes[3] = 8'h23;
        exp_bytes[4] = 8'h0A; exp_bytes[5] = 8'hBC;
        exp_bytes[6] = 8'h00; exp_bytes[7] = 8'h00;
        exp_bytes[8] = 8'h0F; exp_bytes[9] = 8'hFF;
        exp_bytes[10] = 8'h64;  // 01^23^0A^BC^00^00^0F^FF
    endtask

    initial begin
        int n, t, t1, t2, t3, dc0, bf0;
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0; date_a = '0; date_b = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_txd", 32'(txd_a), 32'd1);
        check("reset_busy", 32'(busy_a), 32'd0);
        check("reset_done", 32'(done_a), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_txd", 32'(txd_a), 32'd1);

        // Basic frame with latency checks.
        set_exp_a();
        send_a(1'b0, n);
        check("busy_after_start", 32'(busy_a), 32'd1);
        check("txd_before_hdr", 32'(txd_a), 32'd1);
        @(negedge clk);
        check("hdr0_start_bit", 32'(txd_a), 32'd0);
        wait_done(0, 1200, t);
        check("done_latency", 32'(t - n), 32'd1005);
        check("busy_falls_with_done", 32'(busy_a), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(done_a), 32'd0);
        repeat (20) @(negedge clk);
        check_frame(0, "basic", NB);

        // Reset in the start bit of the first byte of a second frame.
        send_a(1'b0, n);
        repeat (3) @(negedge clk);
        check("pre_reset_txd", 32'(txd_a), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("async_reset_txd", 32'(txd_a), 32'd1);
        check("async_reset_busy", 32'(busy_a), 32'd0);
        check("async_reset_done", 32'(done_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        q_a.delete();
        q_b.delete();

        // Clean frame after reset; start pulses in CAPTURE and HDR1 are ignored.
        dc0 = done_cnt_a;
        bf0 = bfall_a;
        send_a(1'b1, n);
        repeat (146) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(0, 1200, t);
        check("ignore_done_latency", 32'(t - n), 32'd1005);
        repeat (1200) @(negedge clk);
        check("ignore_one_done", 32'(done_cnt_a - dc0), 32'd1);
        check("ignore_busy_one_fall", 32'(bfall_a - bf0), 32'd1);
        check_frame(0, "ignore", NB);
        q_a.delete();

        // Held start: three back-to-back frames with one IDLE cycle between them.
        dc0 = done_cnt_a;
        start_a = 1'b1;
        date_a  = 12'h000;
        wait_done(0, 1200, t1);
        wait_done(0, 1200, t2);
        repeat (2) @(negedge clk);
        start_a = 1'b0;
        wait_done(0, 1200, t3);
        check("held_spacing_1", 32'(t2 - t1), 32'd1006);
        check("held_spacing_2", 32'(t3 - t2), 32'd1006);
        repeat (1200) @(negedge clk);
        check("held_done_count", 32'(done_cnt_a - dc0), 32'd3);
        check("held_byte_count", 32'(q_a.size()), 32'(3 * NB));

        // Decimation by 3 on DUT B: date_in counts edges since the accepting edge.
        exp_bytes[0] = 8'hA5; exp_bytes[1] = 8'h5A;
        exp_bytes[2] = 8'h00; exp_bytes[3] = 8'h01;
        exp_bytes[4] = 8'h00; exp_bytes[5] = 8'h04;
        exp_bytes[6] = 8'h00; exp_bytes[7] = 8'h07;
        exp_bytes[8] = 8'h00; exp_bytes[9] = 8'h0A;
        exp_bytes[10] = 8'h08;  // 01^04^07^0A
        start_b = 1'b1;
        date_b  = 12'd0;
        n = cyc + 1;
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            start_b = 1'b0;
            date_b  = 12'(j);
        end
        wait_done(1, 1200, t);
        check("decim_done_latency", 32'(t - n), 32'd1011);
        repeat (20) @(negedge clk);
        check_frame(1, "decim", NB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
